// File: rtl/axi_video_stream2btpipe.sv
// Video capture bridge: frame-aligned AXI4-Stream (2 px/beat, GBR) to FrontPanel
// BlockPipeOut. Beats are reordered to R,G,B bytes, packed two beats into three
// 32-bit words, buffered in a FIFO and offered to the host in whole blocks.
module axi_video_stream2btpipe #(
    parameter int FIFO_DEPTH  = 4096,
    parameter int BLOCK_WORDS = 256
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [47:0] s_rgb_axis_tdata,
    input  logic [5:0]  s_rgb_axis_tkeep,
    input  logic        s_rgb_axis_tvalid,
    output logic        s_rgb_axis_tready,
    input  logic        s_rgb_axis_tuser,
    input  logic        s_rgb_axis_tlast,
    input  logic [31:0] wi10_transfers_in_line,
    input  logic [31:0] wi11_transfers_in_frame,
    input  logic [31:0] wi12_frames_in_batch,
    input  logic [31:0] ti40_trigger,
    output logic        ti40_clk,
    output logic [31:0] wo31_status,
    input  logic        btpoA0_read,
    input  logic        btpoA0_blockstrobe,
    output logic        btpoA0_ready,
    output logic [31:0] btpoA0_datain
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] BLOCK_C    = CW'(BLOCK_WORDS);
    localparam logic [CW-1:0] ROOM_LIM_C = CW'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_CAPTURE, ST_DRAIN} state_t;

    // Per pixel: host byte0=R, byte1=G, byte2=B; second pixel in the upper 24 bits.
    function automatic logic [47:0] reorder_f(input logic [47:0] d);
        return {d[39:32], d[31:24], d[47:40], d[15:8], d[7:0], d[23:16]};
    endfunction

    state_t        state_r, state_nx;
    logic [31:0]   line_cnt_r, frame_cnt_r, batch_cnt_r, line_nx, frame_nx, batch_nx;
    logic          phase_r, phase_nx, pend_r, pend_nx;
    logic [15:0]   hold_r, hold_nx;
    logic [31:0]   pend_data_r, pend_data_nx;
    logic          done_r, done_nx, sync_err_r, sync_err_nx, read_err_r, read_err_nx;
    logic          busy_r, nonempty_r, tready_r, tready_nx, ready_r;
    logic [31:0]   datain_r;
    logic [AW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nx, rd_ptr_nx;
    logic [CW-1:0] count_r, count_nx;
    logic [31:0]   mem_r [FIFO_DEPTH];

    logic          beat_s, first_s, take_s, start_s, abort_s, flush_s, fifo_empty_s;
    logic          line_end_s, frame_end_s, batch_end_s, sync_hit_s, wr_en_s, rd_en_s;
    logic [31:0]   line_at_s, frame_at_s, batch_at_s, wr_data_s;
    logic [47:0]   beat_rgb_s;
    logic          unused_s;

    assign unused_s     = ^{s_rgb_axis_tkeep, btpoA0_blockstrobe, ti40_trigger[31:2]};
    assign ti40_clk     = aclk;
    assign start_s      = ti40_trigger[0];
    assign abort_s      = ti40_trigger[1];
    assign beat_s       = s_rgb_axis_tvalid & tready_r;
    assign fifo_empty_s = (count_r == {CW{1'b0}});
    assign beat_rgb_s   = reorder_f(s_rgb_axis_tdata);
    assign first_s      = (state_r == ST_ARM) & beat_s & s_rgb_axis_tuser;
    assign take_s       = first_s | ((state_r == ST_CAPTURE) & beat_s);
    // The frame-aligning beat counts as position zero of line, frame and batch.
    assign line_at_s    = first_s ? 32'd0 : line_cnt_r;
    assign frame_at_s   = first_s ? 32'd0 : frame_cnt_r;
    assign batch_at_s   = first_s ? 32'd0 : batch_cnt_r;
    assign line_end_s   = (line_at_s == wi10_transfers_in_line - 32'd1);
    assign frame_end_s  = (frame_at_s == wi11_transfers_in_frame - 32'd1);
    assign batch_end_s  = frame_end_s & (batch_at_s + 32'd1 == wi12_frames_in_batch);
    assign sync_hit_s   = (s_rgb_axis_tlast != line_end_s) |
                          (s_rgb_axis_tuser & (frame_at_s != 32'd0)) |
                          (~s_rgb_axis_tuser & (frame_at_s == 32'd0));

    assign s_rgb_axis_tready = tready_r;
    assign btpoA0_ready      = ready_r;
    assign btpoA0_datain     = datain_r;
    assign wo31_status       = {27'd0, read_err_r, sync_err_r, nonempty_r, done_r, busy_r};

    // Next-state logic for the capture FSM, gearbox, counters, flags and FIFO pointers
    always_comb begin
        state_nx     = state_r;
        line_nx      = line_cnt_r;
        frame_nx     = frame_cnt_r;
        batch_nx     = batch_cnt_r;
        phase_nx     = phase_r;
        hold_nx      = hold_r;
        pend_nx      = pend_r;
        pend_data_nx = pend_data_r;
        done_nx      = done_r;
        sync_err_nx  = sync_err_r;
        read_err_nx  = read_err_r | (btpoA0_read & fifo_empty_s);
        wr_en_s      = 1'b0;
        wr_data_s    = 32'd0;
        rd_en_s      = btpoA0_read & ~fifo_empty_s;
        flush_s      = 1'b0;

        // Gearbox: a phase-1 beat emits two words, the second on the following cycle.
        if (take_s) begin
            wr_en_s     = 1'b1;
            phase_nx    = ~phase_r;
            line_nx     = line_end_s ? 32'd0 : line_at_s + 32'd1;
            frame_nx    = frame_end_s ? 32'd0 : frame_at_s + 32'd1;
            batch_nx    = batch_at_s + {31'd0, frame_end_s};
            sync_err_nx = sync_err_r | sync_hit_s;
            if (!phase_r) begin
                wr_data_s = beat_rgb_s[31:0];
                hold_nx   = beat_rgb_s[47:32];
            end else begin
                wr_data_s    = {beat_rgb_s[15:0], hold_r};
                pend_nx      = 1'b1;
                pend_data_nx = beat_rgb_s[47:16];
            end
        end else if (pend_r) begin
            wr_en_s   = 1'b1;
            wr_data_s = pend_data_r;
            pend_nx   = 1'b0;
        end else begin
            wr_en_s = 1'b0;
        end

        case (state_r)
            ST_IDLE:    state_nx = ST_IDLE;
            ST_ARM:     state_nx = first_s ? (batch_end_s ? ST_DRAIN : ST_CAPTURE) : ST_ARM;
            ST_CAPTURE: state_nx = (take_s & batch_end_s) ? ST_DRAIN : ST_CAPTURE;
            ST_DRAIN: begin
                if (fifo_empty_s && !pend_r) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = ST_DRAIN;
                end
            end
            default:    state_nx = ST_IDLE;
        endcase

        // Start acts as abort plus re-arm; only start clears the sticky errors.
        if (start_s || abort_s) begin
            flush_s      = 1'b1;
            state_nx     = start_s ? ST_ARM : ST_IDLE;
            line_nx      = 32'd0;
            frame_nx     = 32'd0;
            batch_nx     = 32'd0;
            phase_nx     = 1'b0;
            hold_nx      = 16'd0;
            pend_nx      = 1'b0;
            pend_data_nx = 32'd0;
            done_nx      = 1'b0;
            wr_en_s      = 1'b0;
            rd_en_s      = 1'b0;
            sync_err_nx  = ~start_s & sync_err_r;
            read_err_nx  = ~start_s & (read_err_r | (btpoA0_read & fifo_empty_s));
        end else begin
            flush_s = 1'b0;
        end

        wr_ptr_nx = flush_s ? {AW{1'b0}} : wr_ptr_r + AW'(wr_en_s);
        rd_ptr_nx = flush_s ? {AW{1'b0}} : rd_ptr_r + AW'(rd_en_s);
        count_nx  = flush_s ? {CW{1'b0}} : count_r + CW'(wr_en_s) - CW'(rd_en_s);
        // Two free words must be reserved before a beat is taken in CAPTURE.
        tready_nx = (state_nx != ST_CAPTURE) | ((count_nx <= ROOM_LIM_C) & ~pend_nx);
    end

    // State, counters, flags and registered outputs
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r     <= ST_IDLE;
            line_cnt_r  <= 32'd0;
            frame_cnt_r <= 32'd0;
            batch_cnt_r <= 32'd0;
            phase_r     <= 1'b0;
            hold_r      <= 16'd0;
            pend_r      <= 1'b0;
            pend_data_r <= 32'd0;
            done_r      <= 1'b0;
            sync_err_r  <= 1'b0;
            read_err_r  <= 1'b0;
            busy_r      <= 1'b0;
            nonempty_r  <= 1'b0;
            tready_r    <= 1'b0;
            ready_r     <= 1'b0;
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
        end else begin
            state_r     <= state_nx;
            line_cnt_r  <= line_nx;
            frame_cnt_r <= frame_nx;
            batch_cnt_r <= batch_nx;
            phase_r     <= phase_nx;
            hold_r      <= hold_nx;
            pend_r      <= pend_nx;
            pend_data_r <= pend_data_nx;
            done_r      <= done_nx;
            sync_err_r  <= sync_err_nx;
            read_err_r  <= read_err_nx;
            busy_r      <= (state_nx != ST_IDLE);
            nonempty_r  <= (count_nx != {CW{1'b0}});
            tready_r    <= tready_nx;
            ready_r     <= (count_r >= BLOCK_C);
            wr_ptr_r    <= wr_ptr_nx;
            rd_ptr_r    <= rd_ptr_nx;
            count_r     <= count_nx;
        end
    end

    // FIFO storage write port
    always_ff @(posedge aclk) begin
        if (aresetn && wr_en_s) begin
            mem_r[wr_ptr_r] <= wr_data_s;
        end
    end

    // Registered FIFO read: data appears the cycle after the read strobe
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            datain_r <= 32'd0;
        end else if (rd_en_s) begin
            datain_r <= mem_r[rd_ptr_r];
        end else begin
            datain_r <= datain_r;
        end
    end
endmodule

// File: tb/tb_axi_video_stream2btpipe.sv
// Self-checking bench for axi_video_stream2btpipe: random pixel data, a byte-stream
// reference model of the host word sequence, and one task per scenario.
`timescale 1ns/1ps
module tb_axi_video_stream2btpipe;
    localparam int FIFO_DEPTH  = 16;
    localparam int BLOCK_WORDS = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [47:0] tdata;
    logic        tvalid, tready, tuser, tlast;
    logic [31:0] cfg_line, cfg_frame, cfg_frames, trig;
    logic        ti40_clk;
    logic [31:0] wo31_status;
    logic        btpoA0_read, btpoA0_ready;
    logic [31:0] btpoA0_datain;

    int          checks = 0;
    int          errors = 0;
    int          sent_cnt = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  byte_q [$];
    logic [31:0] got_q [$];

    axi_video_stream2btpipe #(.FIFO_DEPTH(FIFO_DEPTH), .BLOCK_WORDS(BLOCK_WORDS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_rgb_axis_tdata(tdata), .s_rgb_axis_tkeep(6'h3f),
        .s_rgb_axis_tvalid(tvalid), .s_rgb_axis_tready(tready),
        .s_rgb_axis_tuser(tuser), .s_rgb_axis_tlast(tlast),
        .wi10_transfers_in_line(cfg_line), .wi11_transfers_in_frame(cfg_frame),
        .wi12_frames_in_batch(cfg_frames), .ti40_trigger(trig), .ti40_clk(ti40_clk),
        .wo31_status(wo31_status), .btpoA0_read(btpoA0_read),
        .btpoA0_blockstrobe(1'b0), .btpoA0_ready(btpoA0_ready),
        .btpoA0_datain(btpoA0_datain)
    );

    always #5 aclk = ~aclk;

    // Reference: each captured beat contributes R,G,B,R,G,B to a byte stream that the
    // host reads as little-endian 32-bit words.
    function automatic void model_push(input logic [47:0] d);
        logic [31:0] w;
        byte_q.push_back(d[23:16]); byte_q.push_back(d[7:0]);   byte_q.push_back(d[15:8]);
        byte_q.push_back(d[47:40]); byte_q.push_back(d[31:24]); byte_q.push_back(d[39:32]);
        while (byte_q.size() >= 4) begin
            w = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
            repeat (4) void'(byte_q.pop_front());
            exp_q.push_back(w);
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        byte_q.delete();
    endfunction

    task automatic pulse_trigger(input logic [31:0] v);
        trig = v;
        @(posedge aclk);
        @(negedge aclk);
        trig = 32'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic send_beat(input logic [47:0] d, input logic u, input logic l);
        int n = 0;
        tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
        while (tready !== 1'b1 && n < 400) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL send_timeout tready stuck at %b want 1", tready);
        end
        @(posedge aclk);
        @(negedge aclk);
        tvalid = 1'b0;
        sent_cnt++;
    endtask

    // Sends beats [b0, b1) of a captured stream; sync_bad moves the first line's tlast.
    task automatic send_range(input int b0, input int b1, input bit fixed, input bit sync_bad);
        logic [63:0] rnd;
        logic [47:0] d;
        logic        l;
        for (int b = b0; b < b1; b++) begin
            rnd = {$urandom, $urandom};
            d = fixed ? 48'h060504030201 : rnd[47:0];
            l = ((b % int'(cfg_line)) == int'(cfg_line) - 1);
            if (sync_bad && b == 2) l = 1'b1;
            if (sync_bad && b == 3) l = 1'b0;
            model_push(d);
            send_beat(d, (b % int'(cfg_frame)) == 0, l);
        end
    endtask

    task automatic read_words(input int n);
        int guard = 0;
        got_q.delete();
        while (got_q.size() < n && guard < 2000) begin
            if (wo31_status[2] === 1'b1) begin
                btpoA0_read = 1'b1;
                @(posedge aclk);
                @(negedge aclk);
                btpoA0_read = 1'b0;
                got_q.push_back(btpoA0_datain);
            end else begin
                @(negedge aclk);
                guard++;
            end
        end
        if (got_q.size() < n) begin
            checks++; errors++;
            $display("FAIL read_timeout got %0d words want %0d", got_q.size(), n);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (wo31_status[1] !== 1'b1 && n < 60) begin
            @(negedge aclk);
            n++;
        end
    endtask

    task automatic configure(input int line, input int frame, input int frames);
        cfg_line = 32'(line); cfg_frame = 32'(frame); cfg_frames = 32'(frames);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        idle(3);
        checks++;
        if (tready !== 1'b0 || btpoA0_ready !== 1'b0 || btpoA0_datain !== 32'd0 || wo31_status !== 32'd0) begin
            errors++;
            $display("FAIL reset_values tready=%b ready=%b datain=%h status=%h want 0/0/0/0",
                     tready, btpoA0_ready, btpoA0_datain, wo31_status);
        end
        aresetn = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (tready !== 1'b1 || wo31_status !== 32'd0) begin
            errors++;
            $display("FAIL reset_idle tready=%b status=%h want 1/0", tready, wo31_status);
        end
    endtask

    task automatic test_basic_frame();
        configure(4, 8, 1);
        model_clear();
        pulse_trigger(32'd1);
        checks++;
        if (wo31_status !== 32'h1) begin
            errors++; $display("FAIL basic_armed status=%h want 1", wo31_status);
        end
        send_range(0, 2, 1'b1, 1'b0);
        idle(3);
        checks++;
        if (btpoA0_ready !== 1'b0) begin
            errors++; $display("FAIL basic_ready_3words ready=%b want 0", btpoA0_ready);
        end
        send_range(2, 3, 1'b1, 1'b0);
        idle(3);
        checks++;
        if (btpoA0_ready !== 1'b1) begin
            errors++; $display("FAIL basic_ready_4words ready=%b want 1", btpoA0_ready);
        end
        send_range(3, 8, 1'b1, 1'b0);
        idle(3);
        checks++;
        if (wo31_status !== 32'h5) begin
            errors++; $display("FAIL basic_drain_status status=%h want 5", wo31_status);
        end
        read_words(12);
        checks++;
        if (got_q.size() !== 12 || got_q[0] !== 32'h06020103) begin
            errors++; $display("FAIL basic_word0 n=%0d word0=%h want 12/06020103", got_q.size(), got_q[0]);
        end
        foreach (got_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL basic_word%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        wait_done();
        checks++;
        if (wo31_status !== 32'h2) begin
            errors++; $display("FAIL basic_done status=%h want 2", wo31_status);
        end
    endtask

    task automatic test_arm_midstream();
        logic [63:0] rnd;
        configure(4, 8, 1);
        model_clear();
        pulse_trigger(32'd1);
        for (int k = 0; k < 5; k++) begin
            rnd = {$urandom, $urandom};
            send_beat(rnd[47:0], 1'b0, (k % 4) == 3);
        end
        send_range(0, 8, 1'b0, 1'b0);
        read_words(12);
        foreach (got_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL arm_word%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        wait_done();
        checks++;
        if (wo31_status !== 32'h2) begin
            errors++; $display("FAIL arm_done status=%h want 2", wo31_status);
        end
    endtask

    task automatic test_back_to_back();
        configure(4, 16, 1);
        model_clear();
        pulse_trigger(32'd1);
        sent_cnt = 0;
        fork
            send_range(0, 16, 1'b0, 1'b0);
            begin
                idle(40);
                checks++;
                if (tready !== 1'b0 || btpoA0_ready !== 1'b1 || sent_cnt !== 10) begin
                    errors++;
                    $display("FAIL bp_stall tready=%b ready=%b beats=%0d want 0/1/10",
                             tready, btpoA0_ready, sent_cnt);
                end
                read_words(24);
            end
        join
        checks++;
        if (got_q.size() !== 16 * 3 / 2) begin
            errors++; $display("FAIL bp_count got %0d want %0d", got_q.size(), 16 * 3 / 2);
        end
        foreach (got_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_word%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        wait_done();
        checks++;
        if (wo31_status !== 32'h2) begin
            errors++; $display("FAIL bp_done status=%h want 2", wo31_status);
        end
    endtask

    task automatic test_sync_error();
        configure(4, 8, 1);
        model_clear();
        pulse_trigger(32'd1);
        send_range(0, 8, 1'b0, 1'b1);
        read_words(12);
        foreach (got_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL sync_word%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        wait_done();
        checks++;
        if (wo31_status !== 32'hA) begin
            errors++; $display("FAIL sync_status status=%h want a", wo31_status);
        end
    endtask

    task automatic test_abort();
        configure(4, 8, 5);
        model_clear();
        pulse_trigger(32'd1);
        checks++;
        if (wo31_status !== 32'h1) begin
            errors++; $display("FAIL abort_start_clears status=%h want 1", wo31_status);
        end
        fork
            send_range(0, 24, 1'b0, 1'b0);
            read_words(24);
        join
        idle(3);
        foreach (got_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL abort_word%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (btpoA0_ready !== 1'b1 || wo31_status !== 32'h5) begin
            errors++; $display("FAIL abort_pre ready=%b status=%h want 1/5", btpoA0_ready, wo31_status);
        end
        pulse_trigger(32'd2);
        idle(2);
        checks++;
        if (btpoA0_ready !== 1'b0 || wo31_status !== 32'h0 || tready !== 1'b1) begin
            errors++;
            $display("FAIL abort_post ready=%b status=%h tready=%b want 0/0/1",
                     btpoA0_ready, wo31_status, tready);
        end
        configure(4, 8, 1);
        model_clear();
        pulse_trigger(32'd1);
        send_range(0, 8, 1'b0, 1'b0);
        read_words(12);
        foreach (got_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL recap_word%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        wait_done();
        checks++;
        if (wo31_status !== 32'h2) begin
            errors++; $display("FAIL recap_done status=%h want 2", wo31_status);
        end
    endtask

    task automatic test_read_error();
        btpoA0_read = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        btpoA0_read = 1'b0;
        checks++;
        if (wo31_status !== 32'h12) begin
            errors++; $display("FAIL rderr_set status=%h want 12", wo31_status);
        end
        pulse_trigger(32'd1);
        checks++;
        if (wo31_status !== 32'h1) begin
            errors++; $display("FAIL rderr_start_clears status=%h want 1", wo31_status);
        end
        btpoA0_read = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        btpoA0_read = 1'b0;
        pulse_trigger(32'd2);
        checks++;
        if (wo31_status !== 32'h10) begin
            errors++; $display("FAIL rderr_abort_keeps status=%h want 10", wo31_status);
        end
        configure(4, 8, 1);
        model_clear();
        pulse_trigger(32'd1);
        send_range(0, 8, 1'b0, 1'b0);
        read_words(12);
        foreach (got_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rderr_word%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        wait_done();
        checks++;
        if (wo31_status !== 32'h2) begin
            errors++; $display("FAIL rderr_done status=%h want 2", wo31_status);
        end
    endtask

    initial begin
        aresetn = 1'b0; tvalid = 1'b0; tdata = 48'd0; tuser = 1'b0; tlast = 1'b0;
        trig = 32'd0; btpoA0_read = 1'b0;
        configure(4, 8, 1);
        @(negedge aclk);
        test_reset();
        test_basic_frame();
        test_arm_midstream();
        test_back_to_back();
        test_sync_error();
        test_abort();
        test_read_error();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
